// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front end: MOSI frames to RAM words, RAM data to MISO.
// Optional frame_err output is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_param #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int TX_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SS_n,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic [DATA_WIDTH+1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,
   output logic                  frame_err
`endif
);

   localparam int FW = DATA_WIDTH + 2;
   localparam int CW = $clog2(FW + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      PH_SHIFT = 2'd0,
      PH_WAIT  = 2'd1,
      PH_TX    = 2'd2,
      PH_HOLD  = 2'd3
   } phase_e;

   state_e                state_q, state_d;
   phase_e                phase_q, phase_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [7:0]            tmo_q, tmo_d;
   logic                  seen_q, seen_d;
   logic [FW-1:0]         rx_sr_q, rx_sr_d;
   logic [FW-1:0]         rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic                  miso_q, miso_d;

   logic [FW-1:0]         rx_next;
   logic                  tx_first;
   logic [DATA_WIDTH-1:0] tx_load;
   logic                  tx_head;
   logic [DATA_WIDTH-1:0] tx_shift;

`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic                  ferr_q, ferr_d;
   logic                  cmd_bad;
`endif

   always_comb begin
      if (MSB_FIRST) begin
         rx_next  = {rx_sr_q[FW-2:0], MOSI};
         tx_first = tx_data[DATA_WIDTH-1];
         tx_load  = {tx_data[DATA_WIDTH-2:0], 1'b0};
         tx_head  = tx_sr_q[DATA_WIDTH-1];
         tx_shift = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
         rx_next  = {MOSI, rx_sr_q[FW-1:1]};
         tx_first = tx_data[0];
         tx_load  = {1'b0, tx_data[DATA_WIDTH-1:1]};
         tx_head  = tx_sr_q[0];
         tx_shift = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
      end
   end

`ifdef SPI_SLAVE_FRAME_ERR_EN
   // Command tag must match the path chosen by the decision bit.
   always_comb begin
      cmd_bad = 1'b0;
      unique case (state_q)
         WRITE:     cmd_bad = rx_next[FW-1];
         READ_ADD:  cmd_bad = (rx_next[FW-1:FW-2] != 2'b10);
         READ_DATA: cmd_bad = (rx_next[FW-1:FW-2] != 2'b11);
         default:   cmd_bad = 1'b0;
      endcase
   end
`endif

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      seen_d     = seen_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_sr_d    = tx_sr_q;
      miso_d     = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ferr_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            phase_d = PH_SHIFT;
            cnt_d   = '0;
            tmo_d   = '0;
            if (!SS_n) state_d = CHK_CMD;
         end
         CHK_CMD: begin
            if (SS_n)        state_d = IDLE;
            else if (!MOSI)  state_d = WRITE;
            else if (seen_q) state_d = READ_DATA;
            else             state_d = READ_ADD;
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               state_d = IDLE;
               phase_d = PH_SHIFT;
               cnt_d   = '0;
               tmo_d   = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
               ferr_d  = (phase_q == PH_SHIFT);
`endif
            end else begin
               unique case (phase_q)
                  PH_SHIFT: begin
                     rx_sr_d = rx_next;
                     if (cnt_q == CW'(FW - 1)) begin
                        cnt_d      = '0;
                        tmo_d      = '0;
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        ferr_d     = cmd_bad;
`endif
                        if (state_q == READ_ADD) seen_d = 1'b1;
                        phase_d = (state_q == READ_DATA) ? PH_WAIT
                                                         : PH_HOLD;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  PH_WAIT: begin
                     // tmo_q==0 is the rx_valid cycle; the window is 1..TX_TIMEOUT.
                     if (tmo_q != 8'd0 && tx_valid) begin
                        miso_d  = tx_first;
                        tx_sr_d = tx_load;
                        cnt_d   = CW'(1);
                        seen_d  = 1'b0;
                        phase_d = PH_TX;
                     end else if (tmo_q == 8'(TX_TIMEOUT)) begin
                        phase_d = PH_HOLD;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        ferr_d  = 1'b1;
`endif
                     end else begin
                        tmo_d = tmo_q + 8'd1;
                     end
                  end
                  PH_TX: begin
                     if (cnt_q < CW'(DATA_WIDTH)) begin
                        miso_d  = tx_head;
                        tx_sr_d = tx_shift;
                        cnt_d   = cnt_q + 1'b1;
                     end else begin
                        cnt_d   = '0;
                        phase_d = PH_HOLD;
                     end
                  end
                  PH_HOLD: begin
                  end
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         phase_q    <= PH_SHIFT;
         cnt_q      <= '0;
         tmo_q      <= '0;
         seen_q     <= 1'b0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_sr_q    <= '0;
         miso_q     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         ferr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         seen_q     <= seen_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_sr_q    <= tx_sr_d;
         miso_q     <= miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         ferr_q     <= ferr_d;
`endif
      end
   end

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q != IDLE);
`ifdef SPI_SLAVE_FRAME_ERR_EN
   assign frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: 8-bit MSB-first and 16-bit LSB-first instances.
module tb_spi_slave_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        ss_a, mosi_a, miso_a, rxv_a, txv_a, busy_a;
   logic [9:0]  rxd_a;
   logic [7:0]  txd_a;
   logic        ss_b, mosi_b, miso_b, rxv_b, txv_b, busy_b;
   logic [17:0] rxd_b;
   logic [15:0] txd_b;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic        ferr_a, ferr_b;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   bit win_a = 1'b0;
   bit win_b = 1'b0;
   logic [9:0]  fa;
   logic [17:0] fb;

   spi_slave_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .TX_TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a),
      .rx_data(rxd_a), .rx_valid(rxv_a), .tx_data(txd_a),
      .tx_valid(txv_a), .busy(busy_a)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      , .frame_err(ferr_a)
`endif
   );

   spi_slave_param #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .TX_TIMEOUT(16)) dut_b (
      .clk(clk), .rst(rst), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b),
      .rx_data(rxd_b), .rx_valid(rxv_b), .tx_data(txd_b),
      .tx_valid(txv_b), .busy(busy_b)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      , .frame_err(ferr_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_a(input logic [9:0] f, input int n);
      ss_a = 1'b0;
      step;
      mosi_a = f[9];
      step;
      for (int i = 0; i < n; i++) begin
         mosi_a = f[9-i];
         step;
      end
   endtask

   task automatic frame_b(input logic [17:0] f, input int n);
      ss_b = 1'b0;
      step;
      mosi_b = f[17];
      step;
      for (int i = 0; i < n; i++) begin
         mosi_b = f[i];
         step;
      end
   endtask

   task automatic close_a;
      ss_a   = 1'b1;
      mosi_a = 1'b0;
      step;
      chk("busy_a_idle", 32'(busy_a), 32'd0);
   endtask

   task automatic close_b;
      ss_b   = 1'b1;
      mosi_b = 1'b0;
      step;
      chk("busy_b_idle", 32'(busy_b), 32'd0);
   endtask

   task automatic tx_a(input logic [7:0] d);
      txv_a = 1'b1;
      txd_a = d;
      step;
      txv_a = 1'b0;
      win_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("miso_a_bit", 32'(miso_a), 32'(d[7-i]));
         step;
      end
      chk("miso_a_tail", 32'(miso_a), 32'd0);
      win_a = 1'b0;
   endtask

   task automatic tx_b(input logic [15:0] d);
      txv_b = 1'b1;
      txd_b = d;
      step;
      txv_b = 1'b0;
      win_b = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("miso_b_bit", 32'(miso_b), 32'(d[i]));
         step;
      end
      chk("miso_b_tail", 32'(miso_b), 32'd0);
      win_b = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rxv_a) begin
            if (q_a.size() == 0)
               chk("rx_a_spurious", 32'(rxv_a), 32'd0);
            else
               chk("rx_a_data", 32'(rxd_a), q_a.pop_front());
         end
         if (rxv_b) begin
            if (q_b.size() == 0)
               chk("rx_b_spurious", 32'(rxv_b), 32'd0);
            else
               chk("rx_b_data", 32'(rxd_b), q_b.pop_front());
         end
         if (!win_a) chk("miso_a_quiet", 32'(miso_a), 32'd0);
         if (!win_b) chk("miso_b_quiet", 32'(miso_b), 32'd0);
      end
   end

   initial begin
      rst = 1'b1;
      ss_a = 1'b1; mosi_a = 1'b0; txv_a = 1'b0; txd_a = '0;
      ss_b = 1'b1; mosi_b = 1'b0; txv_b = 1'b0; txd_b = '0;
      step;
      step;
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_miso_a", 32'(miso_a), 32'd0);
      chk("rst_rxv_a", 32'(rxv_a), 32'd0);
      chk("rst_rxd_a", 32'(rxd_a), 32'd0);
      chk("rst_seen_a", 32'(dut_a.seen_q), 32'd0);
      chk("rst_rxd_b", 32'(rxd_b), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      rst = 1'b0;
      step;

      // write address
      q_a.push_back(32'h0A5);
      frame_a(10'h0A5, 10);
      close_a;

      // read address then read data
      q_a.push_back(32'h203);
      frame_a(10'h203, 10);
      chk("seen_after_ra", 32'(dut_a.seen_q), 32'd1);
      close_a;
      fa = {2'b11, 8'($urandom)};
      q_a.push_back(32'(fa));
      frame_a(fa, 10);
      step;
      step;
      tx_a(8'hC3);
      chk("seen_after_rd", 32'(dut_a.seen_q), 32'd0);
      close_a;

      // read data without prior address goes down the address path
      q_a.push_back(32'h3FF);
      frame_a(10'h3FF, 10);
      chk("seen_after_3ff", 32'(dut_a.seen_q), 32'd1);
      close_a;

      // abort after 5 bits
      frame_a(10'h155, 5);
      ss_a = 1'b1;
      mosi_a = 1'b0;
      step;
      chk("abort_busy", 32'(busy_a), 32'd0);
      chk("abort_seen", 32'(dut_a.seen_q), 32'd1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      chk("abort_ferr", 32'(ferr_a), 32'd1);
`endif
      step;

      // timeout, late tx_valid ignored
      q_a.push_back(32'h35A);
      frame_a(10'h35A, 10);
      repeat (6) step;
      txv_a = 1'b1;
      txd_a = 8'hFF;
      step;
      txv_a = 1'b0;
      repeat (2) step;
      chk("tmo_busy", 32'(busy_a), 32'd1);
      chk("tmo_seen", 32'(dut_a.seen_q), 32'd1);
      close_a;

      // next read goes straight to READ_DATA; tx_valid on the last window cycle
      q_a.push_back(32'h300);
      frame_a(10'h300, 10);
      repeat (4) step;
      tx_a(8'h96);
      chk("edge_seen", 32'(dut_a.seen_q), 32'd0);
      close_a;

      // reset during MISO bit 3
      q_a.push_back(32'h211);
      frame_a(10'h211, 10);
      close_a;
      q_a.push_back(32'h3C0);
      frame_a(10'h3C0, 10);
      step;
      step;
      txv_a = 1'b1;
      txd_a = 8'hC3;
      step;
      txv_a = 1'b0;
      win_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_rd_bit", 32'(miso_a), 32'(txd_a[7-i]));
         step;
      end
      chk("rst_rd_bit3", 32'(miso_a), 32'(txd_a[4]));
      rst = 1'b1;
      ss_a = 1'b1;
      step;
      rst = 1'b0;
      chk("rst_rd_miso", 32'(miso_a), 32'd0);
      chk("rst_rd_busy", 32'(busy_a), 32'd0);
      chk("rst_rd_seen", 32'(dut_a.seen_q), 32'd0);
      win_a = 1'b0;
      step;

      // reset mid-frame after a read address
      q_a.push_back(32'h2AA);
      frame_a(10'h2AA, 10);
      close_a;
      frame_a(10'h3AA, 4);
      rst = 1'b1;
      step;
      rst = 1'b0;
      ss_a = 1'b1;
      mosi_a = 1'b0;
      chk("rst_mf_busy", 32'(busy_a), 32'd0);
      chk("rst_mf_seen", 32'(dut_a.seen_q), 32'd0);
      chk("rst_mf_rxv", 32'(rxv_a), 32'd0);
      chk("rst_mf_rxd", 32'(rxd_a), 32'd0);
      repeat (2) step;

      // 16-bit LSB-first instance
      q_b.push_back(32'h12345);
      frame_b(18'h12345, 18);
      close_b;
      q_b.push_back(32'h20001);
      frame_b(18'h20001, 18);
      chk("b_seen", 32'(dut_b.seen_q), 32'd1);
      close_b;
      fb = {2'b11, 16'($urandom)};
      q_b.push_back(32'(fb));
      frame_b(fb, 18);
      step;
      step;
      tx_b(16'hA5C3);
      chk("b_seen_clr", 32'(dut_b.seen_q), 32'd0);
      close_b;

      repeat (3) step;
      chk("q_a_empty", 32'(q_a.size()), 32'd0);
      chk("q_b_empty", 32'(q_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
